// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider, raster counters and sync/blank timing.
// Sync and blank are delayed PIPE pixels to line up with the colour path.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int DIV       = 2,
    parameter int PIPE      = 2,
    parameter int RGB_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             pixel_tick,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [RGB_W-1:0] rgb_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DW-1:0]         div_cnt;
    logic [9:0]            h_cnt;
    logic [9:0]            v_cnt;
    logic                  tick;
    logic                  hs_raw;
    logic                  vs_raw;
    logic                  von_raw;
    logic [PIPE-1:0][2:0]  dly;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign von_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

    // Stage order {hs, vs, von}; reset value is idle sync, blanked video.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly <= {PIPE{3'b110}};
        end else if (tick) begin
            dly[0] <= {hs_raw, vs_raw, von_raw};
            for (int i = 1; i < PIPE; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign pixel_tick  = tick;
    assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);
    assign hsync       = dly[PIPE-1][2];
    assign vsync       = dly[PIPE-1][1];
    assign video_on    = dly[PIPE-1][0];
    assign rgb_out     = video_on ? rgb_in : '0;

endmodule
